fifo_rd_drain: RTL and testbench

- Read-side drain engine for the asynchronous FIFO. Sits entirely in the read clock domain.
- Converts the FIFO's raw pop interface into a valid/ready stream: read enable, empty flag, and read data valid a fixed number of cycles after the pop.
- Prefetches words into a small local skid buffer so a continuously ready consumer sees one word per clock.
- Counts delivered words and reports idle status.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/drain_skid_buf.sv | 59 +++++
 rtl/fifo_rd_drain.sv | 107 ++++++++++
 tb/tb_fifo_rd_drain.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side logic: latency limits, drain FSM
// state encoding and an occupancy-width helper.
package fifo_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } drain_state_t;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Small circular skid buffer: head/tail pointers plus an occupancy counter.
// The head word is read straight from the storage registers.
module drain_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  localparam int OCC_W     = occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [OCC_W-1:0]      occ_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (pop_i)
      head_d = (head_q == LAST) ? '0 : head_q + PTR_W'(1);
    if (push_i)
      tail_d = (tail_q == LAST) ? '0 : tail_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (push_i) mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_o = mem_q[head_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: turns the FIFO pop interface into a valid/ready
// stream with credit-gated prefetch into a local skid buffer.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  idle
);

  // Out-of-range latencies are clamped to the supported range.
  localparam int LAT   = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;
  localparam int OCC_W = occ_width(BUF_DEPTH);
  localparam int INF_W = occ_width(LAT);
  localparam int SUM_W = occ_width(BUF_DEPTH + LAT + 1);

  drain_state_t          state_q, state_d;
  logic [LAT-1:0]        sr_q, sr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [INF_W-1:0]      inflight;
  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] head;
  logic [SUM_W-1:0]      load, limit;
  logic                  handoff, land, busy;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + INF_W'(sr_q[i]);
  end

  assign m_valid = (occ != '0);
  assign handoff = m_valid && m_ready;
  assign land    = sr_q[LAT-1];
  assign busy    = (occ != '0) || (inflight != '0);

  // A word handed off this cycle frees its slot for a new pop.
  assign load       = SUM_W'(occ) + SUM_W'(inflight);
  assign limit      = SUM_W'(BUF_DEPTH) + SUM_W'(handoff);
  assign fifo_rd_en = drain_en && !fifo_empty && !rst && (load < limit);

  always_comb begin
    sr_d    = '0;
    sr_d[0] = fifo_rd_en;
    for (int i = 1; i < LAT; i++) sr_d[i] = sr_q[i-1];
    cnt_d = cnt_q + CNT_WIDTH'(handoff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (drain_en) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!drain_en) state_d = busy ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (drain_en)   state_d = ST_ACTIVE;
        else if (!busy) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle = (state_q == ST_IDLE);
  end

  drain_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (land),
    .push_data_i(fifo_rd_data),
    .pop_i      (handoff),
    .head_o     (head),
    .occ_o      (occ)
  );

  assign m_data   = head;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: two instances (latency 1 and latency 2), FIFO
// models feeding them, and scoreboards checking every stream hand-off.
module tb_fifo_rd_drain;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got event/timeout, expected none", name);
  endtask

  // Instance A: RD_LATENCY=1, BUF_DEPTH=2, CNT_WIDTH=16
  logic       rst_a, drain_en_a, fifo_rd_en_a, m_valid_a, m_ready_a, idle_a;
  logic       fifo_empty_a = 1'b1;
  logic [7:0] fifo_rd_data_a, m_data_a;
  logic [15:0] word_cnt_a;

  // Instance B: RD_LATENCY=2, BUF_DEPTH=3, CNT_WIDTH=4
  logic       rst_b, drain_en_b, fifo_rd_en_b, m_valid_b, m_ready_b, idle_b;
  logic       fifo_empty_b = 1'b1;
  logic [7:0] fifo_rd_data_b, m_data_b;
  logic [3:0] word_cnt_b;

  fifo_rd_drain #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .drain_en(drain_en_a), .fifo_empty(fifo_empty_a),
    .fifo_rd_en(fifo_rd_en_a), .fifo_rd_data(fifo_rd_data_a), .m_valid(m_valid_a),
    .m_ready(m_ready_a), .m_data(m_data_a), .word_cnt(word_cnt_a), .idle(idle_a));

  fifo_rd_drain #(.DATA_WIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .drain_en(drain_en_b), .fifo_empty(fifo_empty_b),
    .fifo_rd_en(fifo_rd_en_b), .fifo_rd_data(fifo_rd_data_b), .m_valid(m_valid_b),
    .m_ready(m_ready_b), .m_data(m_data_b), .word_cnt(word_cnt_b), .idle(idle_b));

  logic [7:0] mem_a[$], exp_a[$], mem_b[$], exp_b[$];
  logic [7:0] stg_a [2] = '{8'hEE, 8'hEE};
  logic [7:0] stg_b [2] = '{8'hEE, 8'hEE};
  int pops_a = 0, hs_a = 0, pops_b = 0, hs_b = 0;

  // FIFO models: a pop sampled mid-cycle delivers data RD_LATENCY clocks later;
  // the popped word becomes the expected next stream word.
  always begin : model_a
    logic p;
    @(negedge clk); p = fifo_rd_en_a;
    @(posedge clk); #1;
    stg_a[1] = stg_a[0];
    stg_a[0] = 8'hEE;
    if (p) begin
      if (mem_a.size() == 0) fail("model_a_pop_when_empty");
      else begin
        stg_a[0] = mem_a.pop_front();
        exp_a.push_back(stg_a[0]);
        pops_a++;
      end
    end
    fifo_rd_data_a = stg_a[0];
    fifo_empty_a   = (mem_a.size() == 0);
  end

  always begin : model_b
    logic p;
    @(negedge clk); p = fifo_rd_en_b;
    @(posedge clk); #1;
    stg_b[1] = stg_b[0];
    stg_b[0] = 8'hEE;
    if (p) begin
      if (mem_b.size() == 0) fail("model_b_pop_when_empty");
      else begin
        stg_b[0] = mem_b.pop_front();
        exp_b.push_back(stg_b[0]);
        pops_b++;
      end
    end
    fifo_rd_data_b = stg_b[1];
    fifo_empty_b   = (mem_b.size() == 0);
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst_a && m_valid_a && m_ready_a) begin
      hs_a++;
      if (exp_a.size() == 0) fail("sb_a_unexpected_word");
      else chk("sb_a_data", m_data_a, exp_a.pop_front());
    end
    if (!rst_a)
      assert (!(dut_a.u_buf.push_i && !dut_a.u_buf.pop_i && dut_a.u_buf.occ_o == 2))
        else fail("ovf_a_land_without_slot");
  end

  always @(negedge clk) begin
    if (!rst_b && m_valid_b && m_ready_b) begin
      hs_b++;
      if (exp_b.size() == 0) fail("sb_b_unexpected_word");
      else chk("sb_b_data", m_data_b, exp_b.pop_front());
    end
    if (!rst_b)
      assert (!(dut_b.u_buf.push_i && !dut_b.u_buf.pop_i && dut_b.u_buf.occ_o == 3))
        else fail("ovf_b_land_without_slot");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    int pop_c, val_c, cyc, bad;
    logic found;
    logic [7:0] d0;

    rst_a = 1; drain_en_a = 0; m_ready_a = 0;
    rst_b = 1; drain_en_b = 0; m_ready_b = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_a_m_valid", m_valid_a, 0);
    chk("rst_a_m_data", m_data_a, 0);
    chk("rst_a_word_cnt", word_cnt_a, 0);
    chk("rst_a_idle", idle_a, 1);
    chk("rst_a_rd_en", fifo_rd_en_a, 0);
    chk("rst_b_m_valid", m_valid_b, 0);
    chk("rst_b_word_cnt", word_cnt_b, 0);
    chk("rst_b_idle", idle_b, 1);
    tick();
    rst_a = 0; rst_b = 0;

    // T1: three words, latency and count
    mem_a.push_back(8'h11); mem_a.push_back(8'h22); mem_a.push_back(8'h33);
    tick();
    m_ready_a = 1; drain_en_a = 1;
    pop_c = -1; val_c = -100; found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pop_c < 0 && fifo_rd_en_a) pop_c = n;
      if (m_valid_a) begin val_c = n; found = 1; break; end
    end
    if (!found) fail("t1_valid_timeout");
    chk("t1_pop_to_valid", val_c - pop_c, 2);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (word_cnt_a == 16'd3) begin found = 1; break; end
    end
    if (!found) fail("t1_cnt_timeout");
    tick(); drain_en_a = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("t1_word_cnt", word_cnt_a, 3);
    chk("t1_idle", idle_a, 1);
    chk("t1_sb_empty", exp_a.size(), 0);

    // T2: 64-word continuous stream
    for (int i = 0; i < 64; i++) mem_a.push_back(8'(8'h40 + i));
    tick();
    drain_en_a = 1;
    cyc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (word_cnt_a == 16'd67) begin cyc = n; break; end
    end
    if (cyc < 0) fail("t2_cnt_timeout");
    chk("t2_cycles_for_64", cyc, 66);
    tick(); drain_en_a = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("t2_word_cnt", word_cnt_a, 67);
    chk("t2_idle", idle_a, 1);

    // T3: 20-cycle consumer stall mid-stream
    for (int i = 0; i < 30; i++) mem_a.push_back(8'(8'h80 + i));
    tick();
    drain_en_a = 1;
    repeat (5) tick();
    m_ready_a = 0;
    bad = 0;
    @(negedge clk); d0 = m_data_a;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!m_valid_a || m_data_a !== d0) bad++;
    end
    chk("t3_stall_stable", bad, 0);
    chk("t3_outstanding", pops_a - hs_a, 2);
    chk("t3_rd_en_stalled", fifo_rd_en_a, 0);
    tick(); m_ready_a = 1;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (word_cnt_a == 16'd97) begin found = 1; break; end
    end
    if (!found) fail("t3_resume_timeout");
    tick(); drain_en_a = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("t3_sb_empty", exp_a.size(), 0);

    // T4: drain_en drops with a pop in flight
    mem_a.push_back(8'hA1); mem_a.push_back(8'hA2);
    tick();
    drain_en_a = 1;
    tick();
    drain_en_a = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_state_hold", 32'(dut_a.state_q), 32'(ST_HOLD));
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (idle_a) begin found = 1; break; end
    end
    if (!found) fail("t4_idle_timeout");
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (fifo_rd_en_a) bad++;
    end
    chk("t4_rd_en_quiet", bad, 0);
    chk("t4_word_cnt", word_cnt_a, 98);
    chk("t4_sb_empty", exp_a.size(), 0);
    mem_a.delete();

    // T5: latency 2, 4-bit counter wraps after 17 words
    for (int i = 0; i < 17; i++) mem_b.push_back(8'(i + 1));
    tick();
    m_ready_b = 1; drain_en_b = 1;
    pop_c = -1; val_c = -100; found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pop_c < 0 && fifo_rd_en_b) pop_c = n;
      if (m_valid_b) begin val_c = n; found = 1; break; end
    end
    if (!found) fail("t5_valid_timeout");
    chk("t5_pop_to_valid", val_c - pop_c, 3);
    found = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (hs_b == 17) begin found = 1; break; end
    end
    if (!found) fail("t5_stream_timeout");
    @(negedge clk);
    chk("t5_word_cnt_wrap", word_cnt_b, 1);
    tick(); drain_en_b = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("t5_idle", idle_b, 1);
    chk("t5_sb_empty", exp_b.size(), 0);

    // T6: reset with occ=2 and one pop in flight
    for (int i = 0; i < 8; i++) mem_b.push_back(8'(8'hB0 + i));
    tick();
    m_ready_b = 0; drain_en_b = 1;
    repeat (4) tick();
    rst_b = 1;
    @(negedge clk);
    chk("t6_outstanding_before_rst", pops_b - hs_b, 3);
    tick();
    rst_b = 0; drain_en_b = 0;
    @(negedge clk);
    chk("t6_m_valid", m_valid_b, 0);
    chk("t6_m_data", m_data_b, 0);
    chk("t6_word_cnt", word_cnt_b, 0);
    chk("t6_idle", idle_b, 1);
    chk("t6_rd_en", fifo_rd_en_b, 0);
    exp_b.delete();
    mem_b.delete();
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
